gpio_bank: RTL
==============

# gpio_bank

Parametrised GPIO bank that generalises the fixed write/read port GPIO pair to NUM_PINS bidirectional pins. Each pin has a direction bit, an output bit, an input synchroniser, a debounce filter, rising/falling edge capture, and an interrupt. Software-side access is a simple single-clock register port. The bank sits between the bus-side register fabric and the chip pads, and is the DUT target for the gpio interface agent.

## Interface

- NUM_PINS, 16: number of pins, 1..32.
- SYNC_STAGES, 2: input synchroniser flops per pin, >=2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must differ from the filtered level before it is accepted, >=1.

- clk  in  1  bank clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one write per asserted cycle.
- rd_en  in  1  register read strobe.
- addr  in  3  register address.
- wdata  in  NUM_PINS  write data.
- rdata  out  NUM_PINS  read data, valid when rvalid=1.
- rvalid  out  1  one-cycle pulse, the cycle after rd_en.
- pin_in  in  NUM_PINS  asynchronous pad inputs.
- pin_out  out  NUM_PINS  pad output values.
- pin_oe  out  NUM_PINS  pad output enables; 1 = drive.
- irq  out  1  level interrupt.

## Operation

- Register map:
  - 0 DIR (RW)
  - 1 OUT (RW)
  - 2 IN (RO, filtered level)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 IRQ_EN (RW)
  - 6 STATUS (RW1C)
  - 7 OUT_TGL (WO; each 1 bit inverts the OUT bit; reads 0)
- Writes to RO addresses are ignored.
- pin_oe = DIR and pin_out = OUT, both driven directly from registers.
- Per-pin input path: pin_in goes through SYNC_STAGES flops, giving sync, then into the debounce stage.
- Debounce stage: counter cnt plus filtered level filt.
  - If sync == filt: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: filt <= sync and cnt <= 0 (accept).
  - Else: cnt <= cnt+1.
  - Any bounce back to filt before acceptance restarts the count.
- Edge capture happens on the accept edge, for pins with DIR=0 only:
  - STATUS[i] <= 1 if the new filt is 1 and RISE_EN[i] = 1.
  - STATUS[i] <= 1 if the new filt is 0 and FALL_EN[i] = 1.
- Output pins (DIR=1) still update filt/IN but never set STATUS.
- STATUS bits are sticky and are cleared only by writing 1 to addr 6.
- irq = |(STATUS & IRQ_EN), combinational from registers.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert) clears all registers, sync flops, filt, cnt, rvalid and rdata.
  - Outputs during reset: pin_oe=0, pin_out=0, irq=0, rvalid=0, rdata=0.
- After reset, filt starts at 0. A pin held high therefore accepts a rising edge after the latency below; STATUS is unaffected because RISE_EN=0.
- Input latency: a pin change stable before edge 0 updates filt/IN and STATUS at edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults that is edge 5, i.e. six rising edges including edge 0.
- irq rises in the same cycle STATUS updates. irq falls in the cycle after the W1C write edge.
- Read: rd_en at edge n gives rdata/rvalid valid after edge n, for exactly one cycle. Read data is sampled from pre-edge register values.
- Simultaneous rd_en and wr_en on the same address: the read returns the old value and the write takes effect.
- W1C clear and a new edge event on the same bit in the same cycle: set wins, and STATUS stays 1.
- Writes take effect at the write edge, so pin_out/pin_oe change one cycle after wr_en is sampled.
- Reset asserted mid-debounce discards cnt and filt immediately; no event is generated.

## Test plan

- Reset: assert rst=0 with random pins, then release. Required: every output 0, and reading all addresses returns 0 except IN, which settles to the pin values 6 cycles later.
- Output path: write DIR=0x00FF, OUT=0x00A5, then OUT_TGL=0x000F. Required: pin_oe=0x00FF, then pin_out=0x00A5, then pin_out=0x00AA. OUT_TGL reads 0.
- Debounce, defaults: pin_in[3] high for 3 cycles, low for 1, then high for 4. Required: IN[3] rises exactly 5 edges after the final rise, and stays 0 before that.
- Edge/irq: RISE_EN=0x1, FALL_EN=0x1, IRQ_EN=0x1, then pulse pin_in[0] high for 10 cycles. Required: STATUS=1 and irq=1 at the rising accept; a W1C of 1 clears it; the falling accept sets it again.
- Set-versus-clear race: schedule a W1C to bit 0 on the exact accept edge. Required: STATUS[0] remains 1 and irq stays high.
- Output-pin suppression: DIR[2]=1, RISE_EN[2]=1, then toggle pin_in[2]. Required: IN[2] follows the pin, while STATUS[2] stays 0 and irq stays 0.

Source files
------------

// File: rtl/gpio_bank.sv
// NUM_PINS-wide GPIO bank: direction/output registers, synchronised and debounced
// inputs, edge capture into sticky W1C status, and a level interrupt.
`timescale 1ns/1ps
module gpio_bank #(
    parameter int NUM_PINS        = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [2:0]          addr,
    input  logic [NUM_PINS-1:0] wdata,
    output logic [NUM_PINS-1:0] rdata,
    output logic                rvalid,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic                irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] out_q, out_d;
    logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_w;
    logic [NUM_PINS-1:0] filt_w;
    logic [NUM_PINS-1:0] filt_next_w;
    logic [NUM_PINS-1:0] accept_w;
    logic [NUM_PINS-1:0] evt_set_w;
    logic [NUM_PINS-1:0] w1c_w;
    logic [NUM_PINS-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Per-pin debounce: a level must differ from filt for DEBOUNCE_CYCLES
    // consecutive cycles; any return to filt restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             filt_q, filt_d;
            logic             accept;

            always_comb begin
                cnt_d  = cnt_q;
                filt_d = filt_q;
                accept = 1'b0;
                if (sync_w[gi] == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    filt_d = sync_w[gi];
                    cnt_d  = '0;
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_w[gi]      = filt_q;
            assign filt_next_w[gi] = filt_d;
            assign accept_w[gi]    = accept;
        end
    endgenerate

    // Only input pins report edges; output pins still track the pad level in IN.
    assign evt_set_w = accept_w & ~dir_q &
                       ((filt_next_w & rise_en_q) | (~filt_next_w & fall_en_q));
    assign w1c_w     = (wr_en && addr == 3'd6) ? wdata : '0;

    always_comb begin
        case (addr)
            3'd0:    rd_mux = dir_q;
            3'd1:    rd_mux = out_q;
            3'd2:    rd_mux = filt_w;
            3'd3:    rd_mux = rise_en_q;
            3'd4:    rd_mux = fall_en_q;
            3'd5:    rd_mux = irq_en_q;
            3'd6:    rd_mux = status_q;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        status_d  = (status_q & ~w1c_w) | evt_set_w;
        rdata_d   = rd_en ? rd_mux : rdata_q;
        rvalid_d  = rd_en;
        if (wr_en) begin
            case (addr)
                3'd0:    dir_d     = wdata;
                3'd1:    out_d     = wdata;
                3'd3:    rise_en_d = wdata;
                3'd4:    fall_en_d = wdata;
                3'd5:    irq_en_d  = wdata;
                3'd7:    out_d     = out_q ^ wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_en_q  <= irq_en_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign pin_oe  = dir_q;
    assign pin_out = out_q;
    assign irq     = |(status_q & irq_en_q);

endmodule
